// File: rtl/crc_stream_if.sv
// Handshake bundle for crc_stream_engine: input beat stream plus CRC result.
// Optional CRC_STREAM_CHECK_EN adds the expected-CRC input and match output.
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              crc_valid;
    logic              crc_ready;
    logic [CRC_W-1:0]  crc_out;
    logic              busy;
`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0]  crc_expected;
    logic              crc_match;

    modport master (
        output in_valid, in_data, in_last, crc_ready, crc_expected,
        input  in_ready, crc_valid, crc_out, busy, crc_match
    );
    modport slave (
        input  in_valid, in_data, in_last, crc_ready, crc_expected,
        output in_ready, crc_valid, crc_out, busy, crc_match
    );
`else
    modport master (
        output in_valid, in_data, in_last, crc_ready,
        input  in_ready, crc_valid, crc_out, busy
    );
    modport slave (
        input  in_valid, in_data, in_last, crc_ready,
        output in_ready, crc_valid, crc_out, busy
    );
`endif
endinterface

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts DATA_W-bit beats, folds BITS_PER_CYC bits per
// clock, presents the finished frame CRC over a valid/ready handshake.
// Optional compare against an expected CRC: define CRC_STREAM_CHECK_EN.
module crc_stream_engine #(
    parameter int               CRC_W        = 16,
    parameter logic [CRC_W-1:0] POLY         = 16'h1021,
    parameter logic [CRC_W-1:0] INIT         = 16'h0000,
    parameter logic [CRC_W-1:0] XOR_OUT      = 16'h0000,
    parameter int               DATA_W       = 8,
    parameter int               BITS_PER_CYC = 8,
    parameter int               REFIN        = 0,
    parameter int               REFOUT       = 0
) (
    input  logic         clk,
    input  logic         rst,
    crc_stream_if.slave  bus
);
    localparam int N     = DATA_W / BITS_PER_CYC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (BITS_PER_CYC < 1 || (DATA_W % BITS_PER_CYC) != 0) begin : g_bad_cfg
        $error("crc_stream_engine: BITS_PER_CYC must divide DATA_W");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CRC_W-1:0]  crc_out_q, crc_out_d;
    logic              crc_valid_q, crc_valid_d;
    logic              busy_q, busy_d;
`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0]  exp_q, exp_d;
    logic              match_q, match_d;
`endif

    logic [CRC_W-1:0]  crc_next;
    logic [DATA_W-1:0] data_shift;
    logic [CRC_W-1:0]  crc_final;
    logic              fb;
    logic              b;

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
        return r;
    endfunction

    // Unrolled fold of one chunk; the working beat is shifted so the next
    // chunk always sits at the same end of data_q.
    always_comb begin
        crc_next = crc_q;
        fb       = 1'b0;
        b        = 1'b0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            b        = (REFIN != 0) ? data_q[i] : data_q[DATA_W-1-i];
            fb       = crc_next[CRC_W-1] ^ b;
            crc_next = (crc_next << 1) ^ (fb ? POLY : '0);
        end
        data_shift = (REFIN != 0) ? (data_q >> BITS_PER_CYC) : (data_q << BITS_PER_CYC);
        crc_final  = ((REFOUT != 0) ? bitrev(crc_next) : crc_next) ^ XOR_OUT;
    end

    // Next-state and registered-output logic for IDLE/SHIFT/RESULT.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        data_d      = data_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = crc_valid_q;
        busy_d      = busy_q;
`ifdef CRC_STREAM_CHECK_EN
        exp_d       = exp_q;
        match_d     = match_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    last_d  = bus.in_last;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef CRC_STREAM_CHECK_EN
                    if (bus.in_last) exp_d = bus.crc_expected;
`endif
                end
            end
            SHIFT: begin
                crc_d  = crc_next;
                data_d = data_shift;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    if (last_q) begin
                        state_d     = RESULT;
                        crc_out_d   = crc_final;
                        crc_valid_d = 1'b1;
`ifdef CRC_STREAM_CHECK_EN
                        match_d     = (crc_final == exp_q);
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESULT: begin
                if (bus.crc_ready) begin
                    crc_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    crc_d       = INIT;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            data_q      <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
            exp_q       <= '0;
            match_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            data_q      <= data_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            busy_q      <= busy_d;
`ifdef CRC_STREAM_CHECK_EN
            exp_q       <= exp_d;
            match_q     <= match_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.busy      = busy_q;
`ifdef CRC_STREAM_CHECK_EN
    assign bus.crc_match = match_q;
`endif
endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: four configurations (default,
// INIT=FFFF, reflected, bit-serial) share one stimulus driver selected by sel.
module tb_crc_stream_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        tb_valid = 1'b0;
    logic [7:0]  tb_data = 8'h00;
    logic        tb_last = 1'b0;
    logic        tb_ready = 1'b0;
    logic [15:0] tb_exp = 16'h0000;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic        rd_ready [4];
    logic        rd_cvalid[4];
    logic        rd_busy  [4];
    logic [15:0] rd_out   [4];
    logic        rd_match [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_stream_if #(.DATA_W(8), .CRC_W(16)) bus [4] ();

    crc_stream_engine u_dflt (.clk(clk), .rst(rst), .bus(bus[0]));
    crc_stream_engine #(.INIT(16'hFFFF)) u_init (.clk(clk), .rst(rst), .bus(bus[1]));
    crc_stream_engine #(.REFIN(1), .REFOUT(1)) u_refl (.clk(clk), .rst(rst), .bus(bus[2]));
    crc_stream_engine #(.BITS_PER_CYC(1)) u_bit (.clk(clk), .rst(rst), .bus(bus[3]));

    for (genvar g = 0; g < 4; g++) begin : g_bus
        assign bus[g].in_valid  = tb_valid && (sel == g);
        assign bus[g].in_data   = tb_data;
        assign bus[g].in_last   = tb_last;
        assign bus[g].crc_ready = tb_ready;
        assign rd_ready[g]      = bus[g].in_ready;
        assign rd_cvalid[g]     = bus[g].crc_valid;
        assign rd_busy[g]       = bus[g].busy;
        assign rd_out[g]        = bus[g].crc_out;
`ifdef CRC_STREAM_CHECK_EN
        assign bus[g].crc_expected = tb_exp;
        assign rd_match[g]         = bus[g].crc_match;
`else
        assign rd_match[g]         = 1'b0;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted; returns #1 after the accept edge.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        tb_valid = 1'b1;
        tb_data  = d;
        tb_last  = l;
        while (rd_ready[sel] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
        tick();
        tb_valid = 1'b0;
    endtask

    // Wait for crc_valid; lat = edges waited, rdy_hi = samples with in_ready high.
    task automatic wait_crc(output logic [15:0] v, output int lat, output int rdy_hi);
        lat = 0;
        rdy_hi = 0;
        while (rd_cvalid[sel] !== 1'b1 && lat < 500) begin
            if (rd_ready[sel] === 1'b1) rdy_hi++;
            tick();
            lat++;
        end
        if (lat >= 500) check("crc_valid_timeout", 32'(lat), 32'd0);
        v = rd_out[sel];
    endtask

    task automatic send_frame();
        for (int i = 0; i < 9; i++) send_beat(8'h31 + 8'(i), i == 8);
    endtask

    initial begin
        logic [15:0] v;
        int          lat;
        int          rh;
        int          t0;

        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #0;
            check("rst_in_ready", 32'(rd_ready[i]), 32'd1);
            check("rst_crc_valid", 32'(rd_cvalid[i]), 32'd0);
            check("rst_crc_out", 32'(rd_out[i]), 32'd0);
            check("rst_busy", 32'(rd_busy[i]), 32'd0);
        end
        rst = 1'b0;
        tb_ready = 1'b1;
        tick();

        // 123456789 on default config; two cycles per beat, 1-cycle valid
        sel = 0;
        send_beat(8'h31, 1'b0);
        t0 = cyc;
        check("t1_busy_mid", 32'(rd_busy[0]), 32'd1);
        for (int i = 1; i < 9; i++) send_beat(8'h31 + 8'(i), i == 8);
        wait_crc(v, lat, rh);
        check("t1_crc", 32'(v), 32'h31C3);
        check("t1_frame_cycles", 32'(cyc - t0), 32'd17);
        check("t1_busy_result", 32'(rd_busy[0]), 32'd1);
        tick();
        check("t1_valid_one_cycle", 32'(rd_cvalid[0]), 32'd0);
        check("t1_busy_clear", 32'(rd_busy[0]), 32'd0);
        check("t1_out_held", 32'(rd_out[0]), 32'h31C3);

        // reset during SHIFT of beat 4, then resend the whole frame
        for (int i = 0; i < 4; i++) send_beat(8'h31 + 8'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 32'(rd_ready[0]), 32'd1);
        check("t5_busy", 32'(rd_busy[0]), 32'd0);
        check("t5_crc_valid", 32'(rd_cvalid[0]), 32'd0);
        check("t5_crc_out", 32'(rd_out[0]), 32'd0);
        repeat (4) tick();
        check("t5_no_crc", 32'(rd_cvalid[0]), 32'd0);
        send_frame();
        wait_crc(v, lat, rh);
        check("t5_resend_crc", 32'(v), 32'h31C3);
        tick();

        // single-beat frames back to back
        send_beat(8'h41, 1'b1);
        wait_crc(v, lat, rh);
        check("t2_crc_41", 32'(v), 32'h58E5);
        check("t2_latency", 32'(lat), 32'd1);
        tick();
        check("t2_ready_after_hs", 32'(rd_ready[0]), 32'd1);
        send_beat(8'h00, 1'b1);
        wait_crc(v, lat, rh);
        check("t2_crc_00", 32'(v), 32'h0000);
        tick();

        // INIT=FFFF and reflected variants
        sel = 1;
        send_frame();
        wait_crc(v, lat, rh);
        check("t3_init_ffff", 32'(v), 32'h29B1);
        tick();
        sel = 2;
        send_frame();
        wait_crc(v, lat, rh);
        check("t3_reflected", 32'(v), 32'h2189);
        tick();

        // bit-serial config with consumer back-pressure
        sel = 3;
        tb_ready = 1'b0;
        send_beat(8'h41, 1'b1);
        wait_crc(v, lat, rh);
        check("t4_crc", 32'(v), 32'h58E5);
        check("t4_shift_cycles", 32'(lat), 32'd8);
        check("t4_ready_low_shift", 32'(rh), 32'd0);
        tb_valid = 1'b1;
        tb_data  = 8'hFF;
        tb_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stall_valid", 32'(rd_cvalid[3]), 32'd1);
            check("t4_stall_out", 32'(rd_out[3]), 32'h58E5);
            check("t4_stall_ready", 32'(rd_ready[3]), 32'd0);
        end
        tb_valid = 1'b0;
        tb_ready = 1'b1;
        tick();
        check("t4_hs_valid", 32'(rd_cvalid[3]), 32'd0);
        check("t4_hs_busy", 32'(rd_busy[3]), 32'd0);
        check("t4_hs_ready", 32'(rd_ready[3]), 32'd1);

`ifdef CRC_STREAM_CHECK_EN
        sel = 0;
        tb_exp = 16'h31C3;
        send_frame();
        wait_crc(v, lat, rh);
        check("t6_match_crc", 32'(v), 32'h31C3);
        check("t6_match_hit", 32'(rd_match[0]), 32'd1);
        tick();
        tb_exp = 16'h31C2;
        send_frame();
        wait_crc(v, lat, rh);
        check("t6_match_miss", 32'(rd_match[0]), 32'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
